// File: rtl/bomber_kbd_pkg.sv
// Shared scan-code constants, direction and decoder-state types for the player keyboard path.
// Key bit layout: [3:0] arrows up/down/left/right, [7:4] WASD up/down/left/right, [8] space.
package bomber_kbd_pkg;

  localparam logic [7:0] KC_EXT   = 8'hE0;
  localparam logic [7:0] KC_BRK   = 8'hF0;
  localparam logic [7:0] KC_UP    = 8'h75;
  localparam logic [7:0] KC_DOWN  = 8'h72;
  localparam logic [7:0] KC_LEFT  = 8'h6B;
  localparam logic [7:0] KC_RIGHT = 8'h74;
  localparam logic [7:0] KC_W     = 8'h1D;
  localparam logic [7:0] KC_S     = 8'h1B;
  localparam logic [7:0] KC_A     = 8'h1C;
  localparam logic [7:0] KC_D     = 8'h23;
  localparam logic [7:0] KC_SPACE = 8'h29;

  localparam int KEY_N     = 9;
  localparam int SPACE_BIT = 8;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE_ST    = 2'd0,
    EXT_ST     = 2'd1,
    BRK_ST     = 2'd2,
    EXT_BRK_ST = 2'd3
  } kbd_state_t;

  // One-hot position of a key in the held mask; all-zero for unmapped codes.
  function automatic logic [KEY_N-1:0] key_bit(input logic [7:0] code, input logic ext);
    key_bit = '0;
    if (ext) begin
      case (code)
        KC_UP:    key_bit[0] = 1'b1;
        KC_DOWN:  key_bit[1] = 1'b1;
        KC_LEFT:  key_bit[2] = 1'b1;
        KC_RIGHT: key_bit[3] = 1'b1;
        default:  key_bit = '0;
      endcase
    end else begin
      case (code)
        KC_W:     key_bit[4] = 1'b1;
        KC_S:     key_bit[5] = 1'b1;
        KC_A:     key_bit[6] = 1'b1;
        KC_D:     key_bit[7] = 1'b1;
        KC_SPACE: key_bit[SPACE_BIT] = 1'b1;
        default:  key_bit = '0;
      endcase
    end
  endfunction

endpackage

// File: rtl/dir_arbiter.sv
// Picks one active direction: the last-pressed one if still held, else fixed priority up>down>left>right.
// Purely combinational; the last-direction register lives in the parent.
module dir_arbiter
  import bomber_kbd_pkg::*;
(
  input  logic [3:0] dir_held,
  input  dir_t       last_dir,
  output dir_t       sel_dir,
  output dir_t       next_last_dir
);

  logic last_held;

  always_comb begin
    last_held = 1'b0;
    case (last_dir)
      DIR_UP:    last_held = dir_held[0];
      DIR_DOWN:  last_held = dir_held[1];
      DIR_LEFT:  last_held = dir_held[2];
      DIR_RIGHT: last_held = dir_held[3];
      default:   last_held = 1'b0;
    endcase
  end

  always_comb begin
    sel_dir = DIR_NONE;
    if (last_held) begin
      sel_dir = last_dir;
    end else if (dir_held[0]) begin
      sel_dir = DIR_UP;
    end else if (dir_held[1]) begin
      sel_dir = DIR_DOWN;
    end else if (dir_held[2]) begin
      sel_dir = DIR_LEFT;
    end else if (dir_held[3]) begin
      sel_dir = DIR_RIGHT;
    end
    next_last_dir = sel_dir;
  end

endmodule

// File: rtl/player_key_decoder.sv
// PS/2 scan-code stream to one-hot direction levels and a frame-aligned bomb pulse; outputs 1 clk after the completing byte.
// No backpressure: a byte is accepted on every kbd_valid strobe.
module player_key_decoder
  import bomber_kbd_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 50000,
  parameter bit          ENABLE_WASD    = 1'b1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] kbd_code,
  input  logic       kbd_valid,
  input  logic       startOfFrame,
  output logic       up_direction_key,
  output logic       down_direction_key,
  output logic       left_direction_key,
  output logic       right_direction_key,
  output logic       drop_bomb,
  output logic       seq_error
);

  localparam int CNT_W = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  kbd_state_t       state, state_nx;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             make_ev, break_ev, ext_ev, err_ev;

  logic [KEY_N-1:0] held_mask, held_nx, key_hit, new_key;
  logic [3:0]       dir_held;
  dir_t             last_dir, cand_last, sel_dir, next_last_dir;
  logic             bomb_set, bomb_pending;

  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign tmo_hit = (state != IDLE_ST) && !kbd_valid && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nx = state;
    make_ev  = 1'b0;
    break_ev = 1'b0;
    ext_ev   = 1'b0;
    err_ev   = 1'b0;
    if (kbd_valid) begin
      case (state)
        IDLE_ST: begin
          if (kbd_code == KC_EXT) begin
            state_nx = EXT_ST;
          end else if (kbd_code == KC_BRK) begin
            state_nx = BRK_ST;
          end else begin
            make_ev = 1'b1;
          end
        end
        EXT_ST: begin
          if (kbd_code == KC_BRK) begin
            state_nx = EXT_BRK_ST;
          end else if (kbd_code == KC_EXT) begin
            err_ev = 1'b1;
          end else begin
            make_ev  = 1'b1;
            ext_ev   = 1'b1;
            state_nx = IDLE_ST;
          end
        end
        BRK_ST, EXT_BRK_ST: begin
          state_nx = IDLE_ST;
          if (kbd_code == KC_EXT || kbd_code == KC_BRK) begin
            err_ev = 1'b1;
          end else begin
            break_ev = 1'b1;
            ext_ev   = (state == EXT_BRK_ST);
          end
        end
        default: state_nx = IDLE_ST;
      endcase
    end else if (tmo_hit) begin
      state_nx = IDLE_ST;
      err_ev   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE_ST;
      tmo_cnt   <= '0;
      seq_error <= 1'b0;
    end else begin
      state     <= state_nx;
      seq_error <= err_ev;
      if (kbd_valid || state == IDLE_ST || tmo_hit) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Held-mask update and last-pressed tracking; only fresh presses move last_dir.
  always_comb begin
    key_hit  = key_bit(kbd_code, ext_ev);
    held_nx  = held_mask;
    new_key  = '0;
    if (make_ev) begin
      new_key = key_hit & ~held_mask;
      held_nx = held_mask | key_hit;
    end else if (break_ev) begin
      held_nx = held_mask & ~key_hit;
    end
    dir_held  = held_nx[3:0] | (held_nx[7:4] & {4{ENABLE_WASD}});
    cand_last = last_dir;
    for (int i = 0; i < 4; i++) begin
      if (new_key[i] || (ENABLE_WASD && new_key[i+4])) begin
        cand_last = dir_t'(3'(i + 1));
      end
    end
    bomb_set = new_key[SPACE_BIT];
  end

  dir_arbiter u_dir_arbiter (
    .dir_held      (dir_held),
    .last_dir      (cand_last),
    .sel_dir       (sel_dir),
    .next_last_dir (next_last_dir)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      held_mask           <= '0;
      last_dir            <= DIR_NONE;
      up_direction_key    <= 1'b0;
      down_direction_key  <= 1'b0;
      left_direction_key  <= 1'b0;
      right_direction_key <= 1'b0;
      bomb_pending        <= 1'b0;
      drop_bomb           <= 1'b0;
    end else begin
      held_mask           <= held_nx;
      last_dir            <= next_last_dir;
      up_direction_key    <= (sel_dir == DIR_UP);
      down_direction_key  <= (sel_dir == DIR_DOWN);
      left_direction_key  <= (sel_dir == DIR_LEFT);
      right_direction_key <= (sel_dir == DIR_RIGHT);
      // A press coincident with startOfFrame stays pending for the next frame.
      drop_bomb           <= startOfFrame && bomb_pending;
      bomb_pending        <= bomb_set || (bomb_pending && !startOfFrame);
    end
  end

endmodule

// File: tb/tb_player_key_decoder.sv
// Table-driven bench with an expected-result queue for player_key_decoder, plus hand sequences for bomb, timeout and reset.
module tb_player_key_decoder;

  logic       clk;
  logic       resetN;
  logic [7:0] kbd_code;
  logic       kbd_valid;
  logic       startOfFrame;
  logic       up_direction_key, down_direction_key, left_direction_key, right_direction_key;
  logic       drop_bomb, seq_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    int         n;
    logic [7:0] b0, b1, b2;
    logic [4:0] exp;   // {up, down, left, right, seq_error}
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];

  player_key_decoder #(
    .PREFIX_TIMEOUT (16),
    .ENABLE_WASD    (1'b1)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .kbd_code            (kbd_code),
    .kbd_valid           (kbd_valid),
    .startOfFrame        (startOfFrame),
    .up_direction_key    (up_direction_key),
    .down_direction_key  (down_direction_key),
    .left_direction_key  (left_direction_key),
    .right_direction_key (right_direction_key),
    .drop_bomb           (drop_bomb),
    .seq_error           (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk_vec(input string nm, input int n, input logic [7:0] b0,
                                  input logic [7:0] b1, input logic [7:0] b2, input logic [4:0] e);
    vec_t v;
    v.name = nm; v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.exp = e;
    return v;
  endfunction

  function automatic logic [4:0] obs();
    return {up_direction_key, down_direction_key, left_direction_key, right_direction_key, seq_error};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    kbd_code  = b;
    kbd_valid = 1'b1;
    @(negedge clk);
    kbd_valid = 1'b0;
  endtask

  task automatic sof_pulse();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  initial begin
    logic [7:0] bs[3];
    resetN       = 1'b0;
    kbd_code     = 8'h00;
    kbd_valid    = 1'b0;
    startOfFrame = 1'b0;

    vecs.push_back(mk_vec("up_make",        2, 8'hE0, 8'h75, 8'h00, 5'b10000));
    vecs.push_back(mk_vec("up_break",       3, 8'hE0, 8'hF0, 8'h75, 5'b00000));
    vecs.push_back(mk_vec("up_again",       2, 8'hE0, 8'h75, 8'h00, 5'b10000));
    vecs.push_back(mk_vec("right_over_up",  2, 8'hE0, 8'h74, 8'h00, 5'b00010));
    vecs.push_back(mk_vec("right_rel",      3, 8'hE0, 8'hF0, 8'h74, 5'b10000));
    vecs.push_back(mk_vec("up_rel",         3, 8'hE0, 8'hF0, 8'h75, 5'b00000));
    vecs.push_back(mk_vec("down_make",      2, 8'hE0, 8'h72, 8'h00, 5'b01000));
    vecs.push_back(mk_vec("left_make",      2, 8'hE0, 8'h6B, 8'h00, 5'b00100));
    vecs.push_back(mk_vec("left_rel_prio",  3, 8'hE0, 8'hF0, 8'h6B, 5'b01000));
    vecs.push_back(mk_vec("down_rel",       3, 8'hE0, 8'hF0, 8'h72, 5'b00000));
    vecs.push_back(mk_vec("w_make",         1, 8'h1D, 8'h00, 8'h00, 5'b10000));
    vecs.push_back(mk_vec("d_make",         1, 8'h23, 8'h00, 8'h00, 5'b00010));
    vecs.push_back(mk_vec("w_autorepeat",   1, 8'h1D, 8'h00, 8'h00, 5'b00010));
    vecs.push_back(mk_vec("d_rel",          2, 8'hF0, 8'h23, 8'h00, 5'b10000));
    vecs.push_back(mk_vec("w_rel",          2, 8'hF0, 8'h1D, 8'h00, 5'b00000));
    vecs.push_back(mk_vec("right3",         2, 8'hE0, 8'h74, 8'h00, 5'b00010));
    vecs.push_back(mk_vec("a3",             1, 8'h1C, 8'h00, 8'h00, 5'b00100));
    vecs.push_back(mk_vec("down3",          2, 8'hE0, 8'h72, 8'h00, 5'b01000));
    vecs.push_back(mk_vec("down3_rel_prio", 3, 8'hE0, 8'hF0, 8'h72, 5'b00100));
    vecs.push_back(mk_vec("a3_rel",         2, 8'hF0, 8'h1C, 8'h00, 5'b00010));
    vecs.push_back(mk_vec("right3_rel",     3, 8'hE0, 8'hF0, 8'h74, 5'b00000));
    vecs.push_back(mk_vec("unmapped",       1, 8'h5A, 8'h00, 8'h00, 5'b00000));
    vecs.push_back(mk_vec("unmapped_ext",   2, 8'hE0, 8'h5A, 8'h00, 5'b00000));
    vecs.push_back(mk_vec("brk_e0_err",     2, 8'hF0, 8'hE0, 8'h00, 5'b00001));
    vecs.push_back(mk_vec("ext_e0_err",     2, 8'hE0, 8'hE0, 8'h00, 5'b00001));
    vecs.push_back(mk_vec("ext_resume",     1, 8'h75, 8'h00, 8'h00, 5'b10000));
    vecs.push_back(mk_vec("extbrk_f0_err",  3, 8'hE0, 8'hF0, 8'hF0, 5'b10001));
    vecs.push_back(mk_vec("up_final_rel",   3, 8'hE0, 8'hF0, 8'h75, 5'b00000));
    vecs.push_back(mk_vec("plain_75",       1, 8'h75, 8'h00, 8'h00, 5'b00000));

    repeat (3) @(negedge clk);
    check("reset_outs", {27'd0, obs()}, 32'd0);
    check("reset_bomb", {31'd0, drop_bomb}, 32'd0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      bs[0] = vecs[i].b0; bs[1] = vecs[i].b1; bs[2] = vecs[i].b2;
      for (int k = 0; k < vecs[i].n; k++) begin
        if (k == vecs[i].n - 1) exp_q.push_back(vecs[i].exp);
        send_byte(bs[k]);
      end
      check(vecs[i].name, {27'd0, obs()}, {27'd0, exp_q.pop_front()});
    end

    // Bomb: one pulse per press, frame-aligned, autorepeat ignored.
    sof_pulse();
    check("bomb_idle", {31'd0, drop_bomb}, 32'd0);
    repeat (4) send_byte(8'h29);
    check("bomb_presof", {31'd0, drop_bomb}, 32'd0);
    sof_pulse();
    check("bomb_pulse", {31'd0, drop_bomb}, 32'd1);
    @(negedge clk);
    check("bomb_one_cycle", {31'd0, drop_bomb}, 32'd0);
    sof_pulse();
    check("bomb_no_repeat", {31'd0, drop_bomb}, 32'd0);
    send_byte(8'hF0); send_byte(8'h29);
    @(negedge clk);
    kbd_code = 8'h29; kbd_valid = 1'b1; startOfFrame = 1'b1;
    @(negedge clk);
    kbd_valid = 1'b0; startOfFrame = 1'b0;
    check("bomb_coincident", {31'd0, drop_bomb}, 32'd0);
    sof_pulse();
    check("bomb_deferred", {31'd0, drop_bomb}, 32'd1);
    send_byte(8'hF0); send_byte(8'h29);
    send_byte(8'h29); send_byte(8'hF0); send_byte(8'h29);
    send_byte(8'h29); send_byte(8'hF0); send_byte(8'h29);
    sof_pulse();
    check("bomb_merged", {31'd0, drop_bomb}, 32'd1);
    sof_pulse();
    check("bomb_merged_once", {31'd0, drop_bomb}, 32'd0);

    // Prefix timeout after a lone E0.
    send_byte(8'hE0);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      check($sformatf("tmo_cyc%0d", i), {31'd0, seq_error}, {31'd0, (i == 16)});
    end
    exp_q.push_back(5'b10000);
    send_byte(8'h1D);
    check("tmo_then_w", {27'd0, obs()}, {27'd0, exp_q.pop_front()});
    send_byte(8'hF0); send_byte(8'h1D);
    check("tmo_w_rel", {27'd0, obs()}, 32'd0);

    // Reset in the middle of a break sequence.
    send_byte(8'hE0); send_byte(8'h75);
    check("rst_pre_up", {27'd0, obs()}, {27'd0, 5'b10000});
    send_byte(8'hE0); send_byte(8'hF0);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("rst_mid_outs", {27'd0, obs()}, 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    send_byte(8'h75);
    check("rst_after_75", {27'd0, obs()}, 32'd0);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("rst_no_stuck", {27'd0, obs()}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
